// File: rtl/cmd_sender.sv
// Host-side DDS link encoder: serialises a latched 32-bit tuning word into the
// command/data byte frame decoded by `communication`, via a UART tx handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; busy=0
// LOAD    | present byte(index) on tx_byte
// SEND    | wait for UART idle, then pulse transmit
// WAIT_HI | wait for tx_busy to rise, bounded by TIMEOUT
// WAIT_LO | wait for tx_busy to fall, then next byte or finish
// DONE    | one-cycle done pulse
module cmd_sender #(
   parameter logic [7:0] CMD_BYTE0  = 8'hA0,
   parameter logic [7:0] CMD_BYTE1  = 8'hA1,
   parameter logic [7:0] CMD_BYTE2  = 8'hA2,
   parameter logic [7:0] CMD_BYTE3  = 8'hA3,
   parameter logic [7:0] CMD_SET    = 8'hA4,
   parameter logic [7:0] CMD_ENABLE = 8'hA5,
   parameter int         TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] m_in,
   input  logic        send_enable,
   output logic        transmit,
   output logic [7:0]  tx_byte,
   input  logic        tx_busy,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT_HI,
      S_WAIT_LO,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    index, index_nxt;
   logic [31:0]   word, word_nxt;
   logic          send_en, send_en_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic          error_nxt;
   logic          transmit_nxt;
   logic [7:0]    tx_byte_nxt;
   logic [7:0]    frame_byte;
   logic [3:0]    last_index;

   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign last_index = send_en ? 4'd9 : 4'd8;

   always_comb begin
      frame_byte = 8'h00;
      case (index)
         4'd0:    frame_byte = CMD_BYTE0;
         4'd1:    frame_byte = word[7:0];
         4'd2:    frame_byte = CMD_BYTE1;
         4'd3:    frame_byte = word[15:8];
         4'd4:    frame_byte = CMD_BYTE2;
         4'd5:    frame_byte = word[23:16];
         4'd6:    frame_byte = CMD_BYTE3;
         4'd7:    frame_byte = word[31:24];
         4'd8:    frame_byte = CMD_SET;
         4'd9:    frame_byte = CMD_ENABLE;
         default: frame_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         index    <= 4'd0;
         word     <= 32'd0;
         send_en  <= 1'b0;
         timer    <= '0;
         error    <= 1'b0;
         transmit <= 1'b0;
         tx_byte  <= 8'h00;
      end else begin
         state    <= state_nxt;
         index    <= index_nxt;
         word     <= word_nxt;
         send_en  <= send_en_nxt;
         timer    <= timer_nxt;
         error    <= error_nxt;
         transmit <= transmit_nxt;
         tx_byte  <= tx_byte_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      index_nxt    = index;
      word_nxt     = word;
      send_en_nxt  = send_en;
      timer_nxt    = timer;
      error_nxt    = error;
      transmit_nxt = 1'b0;
      tx_byte_nxt  = tx_byte;
      case (state)
         S_IDLE: begin
            if (start) begin
               word_nxt    = m_in;
               send_en_nxt = send_enable;
               error_nxt   = 1'b0;
               index_nxt   = 4'd0;
               state_nxt   = S_LOAD;
            end
         end
         S_LOAD: begin
            tx_byte_nxt = frame_byte;
            state_nxt   = S_SEND;
         end
         S_SEND: begin
            // a previous byte may still be shifting out; never overrun the UART
            if (!tx_busy) begin
               transmit_nxt = 1'b1;
               timer_nxt    = '0;
               state_nxt    = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               state_nxt = S_WAIT_LO;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               error_nxt = 1'b1;
               state_nxt = S_IDLE;
            end else if (timer != {TW{1'b1}}) begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (index >= last_index) begin
                  state_nxt = S_DONE;
               end else begin
                  index_nxt = index + 4'd1;
                  state_nxt = S_LOAD;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cmd_sender.sv
// Bench for cmd_sender: UART model, frame reference model and a scoreboard
// monitor that checks every transmitted byte and its timing.
`timescale 1ns/1ps
module tb_cmd_sender;

   localparam int         TIMEOUT = 16;
   localparam logic [7:0] B0 = 8'hA0, B1 = 8'hA1, B2 = 8'hA2, B3 = 8'hA3;
   localparam logic [7:0] BSET = 8'hA4, BEN = 8'hA5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] m_in = 32'd0;
   logic        send_enable = 1'b0;
   logic        transmit;
   logic [7:0]  tx_byte;
   logic        tx_busy;
   logic        busy, done, error;

   logic uart_busy = 1'b0;
   logic hold_busy = 1'b0;
   assign tx_busy = uart_busy | hold_busy;

   int checks = 0, failures = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int frame_tx_cnt = 0;
   int start_cyc = 0, last_drop_cyc = 0, hold_drop_cyc = 0, first_tx_cyc = 0;
   int lat_mode = 0;
   int uart_mode = 0;
   int busy_len = 5;
   int done_cnt = 0;

   cmd_sender #(
      .CMD_BYTE0(B0), .CMD_BYTE1(B1), .CMD_BYTE2(B2), .CMD_BYTE3(B3),
      .CMD_SET(BSET), .CMD_ENABLE(BEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .m_in(m_in), .send_enable(send_enable),
      .transmit(transmit), .tx_byte(tx_byte), .tx_busy(tx_busy),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // reference frame: (command, data byte) per byte lane, then SET, then optional ENABLE
   task automatic push_frame(input logic [31:0] m, input logic en);
      logic [7:0] cmds[4];
      cmds = '{B0, B1, B2, B3};
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(cmds[k]);
         exp_q.push_back(8'((m >> (8 * k)) & 32'hFF));
      end
      exp_q.push_back(BSET);
      if (en) exp_q.push_back(BEN);
   endtask

   task automatic send_frame(input logic [31:0] m, input logic en);
      @(posedge clk); #2;
      m_in = m;
      send_enable = en;
      start = 1'b1;
      start_cyc = cyc;
      frame_tx_cnt = 0;
      push_frame(m, en);
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < budget);
      chk("frame_finished", busy, 0);
   endtask

   task automatic frame_end_checks(input logic en, input int d0);
      chk("done_pulses", done_cnt - d0, 1);
      chk("pulse_count", frame_tx_cnt, en ? 10 : 9);
      chk("queue_drained", exp_q.size(), 0);
      chk("error_clear", error, 0);
   endtask

   // UART model: busy rises the cycle after transmit and stays high busy_len cycles
   always begin
      @(negedge clk);
      if (!rst && transmit && uart_mode == 0) begin
         @(posedge clk); #2;
         uart_busy = 1'b1;
         repeat (busy_len) @(posedge clk);
         #2;
         uart_busy = 1'b0;
         last_drop_cyc = cyc;
      end
   end

   // scoreboard monitor
   always begin
      @(negedge clk);
      if (!rst) begin
         if (done) done_cnt++;
         if (transmit) begin
            chk("tx_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("tx_byte", tx_byte, exp_q.pop_front());
            chk("busy_during_tx", busy, 1);
            if (frame_tx_cnt == 0) begin
               first_tx_cyc = cyc;
               if (lat_mode == 0)
                  chk("start_latency", cyc - start_cyc, 3);
               else
                  chk("held_latency_ok", (cyc - hold_drop_cyc >= 1) && (cyc - hold_drop_cyc <= 3), 1);
            end else if (uart_mode == 0) begin
               chk("byte_gap", cyc - last_drop_cyc, 3);
            end
            frame_tx_cnt++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, n;
      logic [31:0] m;
      logic en;

      #1;
      chk("rst_transmit", transmit, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // reference word without enable, then with enable
      d0 = done_cnt;
      send_frame(32'd157482, 1'b0);
      wait_idle(400);
      frame_end_checks(1'b0, d0);

      d0 = done_cnt;
      send_frame(32'd157482, 1'b1);
      wait_idle(400);
      frame_end_checks(1'b1, d0);

      // m_in change and extra start mid-frame
      d0 = done_cnt;
      send_frame(32'h0002672A, 1'b0);
      n = 0;
      while (frame_tx_cnt < 5 && n < 300) begin @(negedge clk); n++; end
      chk("reached_index4", frame_tx_cnt >= 5, 1);
      @(posedge clk); #2;
      m_in = 32'hFFFFFFFF;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      wait_idle(400);
      frame_end_checks(1'b0, d0);

      // randomized frames; one of them gets a start during its DONE cycle
      for (int f = 0; f < 6; f++) begin
         m = $urandom;
         en = 1'($urandom_range(0, 1));
         busy_len = $urandom_range(1, 6);
         d0 = done_cnt;
         send_frame(m, en);
         if (f == 2) begin
            n = 0;
            while (!done && n < 400) begin @(negedge clk); n++; end
            chk("saw_done", done, 1);
            m_in = $urandom;
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            repeat (4) @(negedge clk);
            chk("start_in_done_ignored", busy, 0);
         end else begin
            wait_idle(400);
         end
         frame_end_checks(en, d0);
      end
      busy_len = 5;

      // asynchronous reset while waiting for tx_busy to fall on byte 3
      send_frame(32'h12345678, 1'b1);
      n = 0;
      while (frame_tx_cnt < 4 && n < 300) begin @(negedge clk); n++; end
      chk("reached_index3", frame_tx_cnt, 4);
      repeat (3) @(negedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_tx_byte", tx_byte, 0);
      chk("async_rst_transmit", transmit, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_error", error, 0);
      exp_q.delete();
      @(posedge clk); #2 rst = 1'b0;
      n = 0;
      while (uart_busy && n < 50) begin @(negedge clk); n++; end
      d0 = done_cnt;
      send_frame(32'hCAFEF00D, 1'b1);
      wait_idle(400);
      frame_end_checks(1'b1, d0);

      // tx_busy already high at start
      hold_busy = 1'b1;
      lat_mode = 1;
      d0 = done_cnt;
      send_frame(32'h0002672A, 1'b0);
      repeat (18) @(posedge clk);
      #2;
      chk("held_no_tx", frame_tx_cnt, 0);
      hold_busy = 1'b0;
      hold_drop_cyc = cyc;
      wait_idle(400);
      frame_end_checks(1'b0, d0);
      lat_mode = 0;

      // UART never answers: timeout, then next start clears error
      uart_mode = 1;
      d0 = done_cnt;
      send_frame(32'hDEADBEEF, 1'b1);
      n = 0;
      while (!error && n < 100) begin @(negedge clk); n++; end
      chk("timeout_error", error, 1);
      chk("timeout_cycles", cyc - first_tx_cyc, TIMEOUT);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_done", done_cnt - d0, 0);
      exp_q.delete();
      uart_mode = 0;
      repeat (3) @(negedge clk);
      chk("error_sticky", error, 1);
      d0 = done_cnt;
      send_frame(32'h01020304, 1'b0);
      @(negedge clk);
      chk("error_cleared_by_start", error, 0);
      wait_idle(400);
      frame_end_checks(1'b0, d0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
